// File: rtl/zx_clock_enables.sv
//==============================================================================
// Module   : zx_clock_enables
// Purpose  : NCO-based 14 MHz tick, pixel/CPU clock enables and core reset
//            sequencer, all running on the 112.5 MHz master clock.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module zx_clock_enables #(
    parameter int ACC_W     = 24,
    parameter int PHASE_INC = 2087831,
    parameter int RST_TICKS = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] turbo,
    input  logic       cpu_hold,
    output logic       ce_14m,
    output logic       ce_7m,
    output logic       ce_cpu_p,
    output logic       ce_cpu_n,
    output logic [1:0] turbo_act,
    output logic       rst_core
);

    localparam logic [ACC_W:0] c_INC  = (ACC_W+1)'(PHASE_INC);
    localparam logic [7:0]     c_LAST = 8'(RST_TICKS - 1);
    localparam logic [1:0]     c_T35  = 2'd0;
    localparam logic [1:0]     c_T7   = 2'd1;
    localparam logic [1:0]     c_T14  = 2'd2;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum_d;
    logic             ce14_q;
    logic [1:0]       div_q;
    logic [1:0]       tpend_q;
    logic [1:0]       tpend_d;
    logic [1:0]       tact_q;
    logic             nsch_q;
    logic             nsch_d;
    logic             rstc_q;
    logic [7:0]       tick_q;
    logic             p_sel;
    logic             n_sel;
    logic             cpu_ok;

    always_comb begin
        sum_d   = {1'b0, acc_q} + c_INC;
        tpend_d = (turbo == 2'd3) ? c_T14 : turbo;
        p_sel   = 1'b0;
        n_sel   = 1'b0;
        case (tact_q)
            c_T35: begin
                p_sel = (div_q == 2'd1);
                n_sel = (div_q == 2'd3);
            end
            c_T7: begin
                p_sel = ~div_q[0];
                n_sel = div_q[0];
            end
            default: begin
                p_sel = 1'b1;
                n_sel = 1'b0;
            end
        endcase
    end

    // The deferred turbo-14 falling edge fires regardless of the current
    // turbo_act so a pair straddling a speed change is never split.
    assign cpu_ok    = ~rstc_q & ~cpu_hold;
    assign ce_14m    = ce14_q;
    assign ce_7m     = ce14_q & div_q[0];
    assign ce_cpu_p  = ce14_q & p_sel & cpu_ok;
    assign ce_cpu_n  = ((ce14_q & n_sel) | nsch_q) & cpu_ok;
    assign nsch_d    = ce_cpu_p & (tact_q == c_T14);
    assign turbo_act = tact_q;
    assign rst_core  = rstc_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q   <= '0;
            ce14_q  <= 1'b0;
            div_q   <= 2'd0;
            tpend_q <= c_T35;
            tact_q  <= c_T35;
            nsch_q  <= 1'b0;
            rstc_q  <= 1'b1;
            tick_q  <= 8'd0;
        end else begin
            acc_q   <= sum_d[ACC_W-1:0];
            ce14_q  <= sum_d[ACC_W];
            tpend_q <= tpend_d;
            nsch_q  <= nsch_d;
            if (ce14_q) begin
                div_q <= div_q + 2'd1;
                if (div_q == 2'd3) begin
                    tact_q <= tpend_q;
                end
            end
            if (rstc_q && ce_7m) begin
                if (tick_q == c_LAST) begin
                    rstc_q <= 1'b0;
                end else begin
                    tick_q <= tick_q + 8'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire
